// File: rtl/sram_pkg.sv
// Shared encodings and defaults for the SRAM access sequencer.
package sram_pkg;

    localparam int unsigned ADDR_W_DEF      = 18;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    // Access codes understood by the pad stage
    localparam logic [1:0] WE_WRITE = 2'b11;
    localparam logic [1:0] WE_READ  = 2'b00;
    localparam logic [1:0] WE_IDLE  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // A zero-length access phase would violate pad timing; clamp to one cycle
    function automatic int unsigned wait_eff(input int unsigned w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// System-side request/response handshake of the SRAM access sequencer.
interface sram_access_ctrl_if
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing the ACCESS phase; saturates at zero.
module sram_wait_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);
endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences single-word SRAM reads/writes through setup, access and turnaround
// phases so the pad access code never jumps between write and read.
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sram_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [1:0]        write_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);
    localparam int unsigned WAIT_EFF = wait_eff(WAIT_CYCLES);
    localparam int unsigned CNT_W    = $clog2(WAIT_EFF + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_EFF - 1);

    state_t     state;
    state_t     state_nxt;
    logic       we_q;
    logic       accept_c;
    logic       load_c;
    logic       dec_c;
    logic       cnt_zero_c;
    logic       capture_c;
    logic [1:0] write_en_nxt;
    logic       rsp_valid_nxt;

    assign bus.req_ready = (state == ST_IDLE) & ~rst;
    assign accept_c      = bus.req_valid & bus.req_ready;

    sram_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .load_val (LOAD_VAL),
        .dec      (dec_c),
        .zero_c   (cnt_zero_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept_c) state_nxt = ST_SETUP;
            ST_SETUP:   state_nxt = ST_ACCESS;
            ST_ACCESS:  if (cnt_zero_c) state_nxt = ST_RECOVER;
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; pad-facing outputs are decoded from the next state so they
    // can be registered without adding a cycle of latency.
    always_comb begin
        write_en_nxt  = WE_IDLE;
        rsp_valid_nxt = 1'b0;
        load_c        = 1'b0;
        dec_c         = 1'b0;
        capture_c     = 1'b0;
        case (state_nxt)
            ST_ACCESS:  write_en_nxt  = we_q ? WE_WRITE : WE_READ;
            ST_RECOVER: rsp_valid_nxt = 1'b1;
            default:    write_en_nxt  = WE_IDLE;
        endcase
        case (state)
            ST_SETUP:  load_c = 1'b1;
            ST_ACCESS: begin
                dec_c     = 1'b1;
                capture_c = cnt_zero_c & ~we_q;
            end
            default:   load_c = 1'b0;
        endcase
    end

    // Registered outputs and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en      <= WE_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            sram_addr     <= '0;
            wr_data       <= '0;
            we_q          <= 1'b0;
        end else begin
            write_en      <= write_en_nxt;
            bus.rsp_valid <= rsp_valid_nxt;
            if (accept_c) begin
                we_q      <= bus.req_we;
                sram_addr <= bus.req_addr;
                wr_data   <= bus.req_wdata;
            end
            if (capture_c) begin
                bus.rsp_rdata <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: vector table, reset/timing corner sequences and
// randomized traffic against a phase-counting transaction model.
module tb_sram_access_ctrl;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [1:0]    write_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sram_addr(sram_addr),
        .write_en(write_en), .wr_data(wr_data), .rd_data(rd_data)
    );

    // Short and long access-phase builds, only checked for latency
    logic [AW-1:0] a1, a5;
    logic [1:0]    we1, we5;
    logic [DW-1:0] wd1, wd5;
    logic [DW-1:0] rd_zero;
    assign rd_zero = '0;
    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus5 ();
    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sram_addr(a1),
        .write_en(we1), .wr_data(wd1), .rd_data(rd_zero)
    );
    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .sram_addr(a5),
        .write_en(we5), .wr_data(wd5), .rd_data(rd_zero)
    );

    // Pad-stage stand-in: 16-word memory indexed by the low address bits
    logic          init_pad;
    logic [DW-1:0] pad_mem [16];
    assign rd_data = pad_mem[sram_addr[3:0]];
    always @(posedge clk) begin
        if (init_pad) begin
            for (int i = 0; i < 16; i++) pad_mem[i] <= 16'h1000 + 16'(i);
        end else if (write_en == 2'b11) begin
            pad_mem[sram_addr[3:0]] <= wr_data;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: ph = cycles since acceptance (0 = idle)
    int            ph;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [16];
    logic [1:0]    prev_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [1:0] e_we;
        logic       adjacent;
        e_we = (ph >= 2 && ph <= int'(W) + 1) ? (m_we ? 2'b11 : 2'b00) : 2'b01;
        adjacent = ((prev_we == 2'b11) && (write_en == 2'b00)) ||
                   ((prev_we == 2'b00) && (write_en == 2'b11));
        chk("write_en", 32'(write_en), 32'(e_we));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ph == int'(W) + 2));
        chk("req_ready", 32'(bus.req_ready), 32'((ph == 0) && !rst));
        chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        chk("wr_data", 32'(wr_data), 32'(m_wdata));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        chk("we_adjacent", 32'(adjacent), 32'd0);
        prev_we = write_en;
    endtask

    // Apply inputs for the current cycle and advance the model across the next edge
    task automatic drive(input logic r, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst           = r;
        bus.req_valid = v;
        bus.req_we    = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        if (r) begin
            ph = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0;
        end else if (ph == 0) begin
            if (v) begin
                ph = 1; m_we = w; m_addr = a; m_wdata = d;
            end
        end else begin
            if (ph == 1 && m_we) ref_mem[m_addr[3:0]] = m_wdata;
            if (ph == int'(W) + 1 && !m_we) m_rdata = ref_mem[m_addr[3:0]];
            ph = (ph == int'(W) + 2) ? 0 : ph + 1;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        check_model();
        drive(r, v, w, a, d);
        @(negedge clk);
    endtask

    typedef struct {
        logic          r, v, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    e_we;
        logic          e_rv, e_rdy;
        logic [DW-1:0] e_rdata;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rsp1, rsp5, acc1, acc5, n1, n5;

        // Write 0xA5C3 to 0x123, then a held read request that is accepted in cycle 5
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 18'h00123, 16'hA5C3, 2'b01, 1'b0, 1'b1, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000, 2'b01, 1'b0, 1'b1, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000, 2'b01, 1'b1, 1'b0, 16'hA5C3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000, 2'b01, 1'b0, 1'b1, 16'hA5C3};

        rst = 1'b1;
        init_pad = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus5.req_valid = 1'b0; bus5.req_we = 1'b0; bus5.req_addr = '0; bus5.req_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h1000 + 16'(i);
        ph = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; prev_we = 2'b01;
        repeat (2) @(negedge clk);
        init_pad = 1'b0;

        // Reset state, then ten idle cycles
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl%0d_write_en", i), 32'(write_en), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_rsp_rdata", i), 32'(bus.rsp_rdata), 32'(tbl[i].e_rdata));
            step(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
        end

        // Reset during the second ACCESS cycle of a read, with a request held across release
        step(1'b0, 1'b1, 1'b0, 18'h00123, 16'h0000);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("abort_in_access", 32'(write_en), 32'(2'b00));
        step(1'b1, 1'b1, 1'b0, 18'h00045, 16'h0000);
        chk("abort_write_en", 32'(write_en), 32'(2'b01));
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
        check_model();
        drive(1'b0, 1'b1, 1'b0, 18'h00045, 16'h0000);
        #1 chk("release_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("release_accept_addr", 32'(sram_addr), 32'h00045);
        for (int i = 0; i < int'(W) + 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("release_read_data", 32'(bus.rsp_rdata), 32'h1005);

        // Access-phase length for the one- and five-cycle builds
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 18'h3; bus1.req_wdata = 16'h1;
        bus5.req_valid = 1'b1; bus5.req_we = 1'b1; bus5.req_addr = 18'h3; bus5.req_wdata = 16'h1;
        rsp1 = -1; rsp5 = -1; acc1 = 0; acc5 = 0; n1 = 0; n5 = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                if (bus1.rsp_valid) begin n1++; if (rsp1 < 0) rsp1 = k; end
                if (bus5.rsp_valid) begin n5++; if (rsp5 < 0) rsp5 = k; end
                if (we1 == 2'b11) acc1++;
                if (we5 == 2'b11) acc5++;
            end
            step(1'b0, 1'b0, 1'b0, '0, '0);
            if (k == 0) begin
                bus1.req_valid = 1'b0;
                bus5.req_valid = 1'b0;
            end
        end
        chk("w1_rsp_cycle", 32'(rsp1), 32'd3);
        chk("w5_rsp_cycle", 32'(rsp5), 32'd7);
        chk("w1_access_len", 32'(acc1), 32'd1);
        chk("w5_access_len", 32'(acc5), 32'd5);
        chk("w1_rsp_count", 32'(n1), 32'd1);
        chk("w5_rsp_count", 32'(n5), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom), DW'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
